// File: rtl/alu_seq_ctrl.sv
// Sequencer that owns a shared ALU and runs one request at a time: single-step ops,
// 1-bit-per-cycle shifts/rotates, and shift-add multiply built from ALU ADD and SL steps.
module alu_seq_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       OPCODE,
  input  logic [WIDTH-1:0] OPERAND1,
  input  logic [WIDTH-1:0] OPERAND2,
  output logic [2:0]       ALU_SELECT,
  output logic [WIDTH-1:0] ALU_DATA1,
  output logic [WIDTH-1:0] ALU_DATA2,
  input  logic [WIDTH-1:0] ALU_RESULT,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned RW = $clog2(WIDTH);

  localparam logic [2:0] OpFwd  = 3'b000;
  localparam logic [2:0] OpAdd  = 3'b001;
  localparam logic [2:0] OpMult = 3'b100;
  localparam logic [2:0] OpSl   = 3'b101;
  localparam logic [2:0] OpRor  = 3'b111;

  typedef enum logic [2:0] {StIdle, StExec, StMulAdd, StMulShift, StFinish} state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             is_shift;

  assign is_shift = op_q[2] && (op_q != OpMult);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    work_d     = work_q;
    op2_d      = op2_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    count_d    = count_q;
    result_d   = result_q;
    zero_d     = zero_q;
    ALU_SELECT = OpFwd;
    ALU_DATA1  = '0;
    ALU_DATA2  = '0;

    unique case (state_q)
      StIdle: begin
        if (START) begin
          op_d     = OPCODE;
          work_d   = OPERAND1;
          op2_d    = OPERAND2;
          acc_d    = '0;
          mcand_d  = OPERAND1;
          mplier_d = OPERAND2;
          // Rotates wrap modulo WIDTH; shifts saturate at WIDTH.
          if (OPCODE == OpRor) begin
            count_d = CW'(OPERAND2[RW-1:0]);
          end else if (OPERAND2 > WIDTH'(WIDTH)) begin
            count_d = CW'(WIDTH);
          end else begin
            count_d = CW'(OPERAND2);
          end
          if (OPCODE == OpMult) begin
            if (OPERAND2 == '0) begin
              state_d  = StFinish;
              result_d = '0;
              zero_d   = 1'b1;
            end else begin
              state_d = OPERAND2[0] ? StMulAdd : StMulShift;
            end
          end else begin
            state_d = StExec;
          end
        end
      end

      StExec: begin
        if (is_shift && (count_q != '0)) begin
          ALU_SELECT = op_q;
          ALU_DATA1  = work_q;
          ALU_DATA2  = WIDTH'(1);
          work_d     = ALU_RESULT;
          count_d    = count_q - CW'(1);
          if (count_q == CW'(1)) begin
            state_d  = StFinish;
            result_d = ALU_RESULT;
            zero_d   = (ALU_RESULT == '0);
          end
        end else begin
          // Zero-count shift is a plain forward of the operand through the ALU.
          ALU_SELECT = is_shift ? OpFwd : op_q;
          ALU_DATA1  = work_q;
          ALU_DATA2  = is_shift ? work_q : op2_q;
          state_d    = StFinish;
          result_d   = ALU_RESULT;
          zero_d     = (ALU_RESULT == '0);
        end
      end

      StMulAdd: begin
        ALU_SELECT = OpAdd;
        ALU_DATA1  = acc_q;
        ALU_DATA2  = mcand_q;
        acc_d      = ALU_RESULT;
        state_d    = StMulShift;
      end

      StMulShift: begin
        ALU_SELECT = OpSl;
        ALU_DATA1  = mcand_q;
        ALU_DATA2  = WIDTH'(1);
        mcand_d    = ALU_RESULT;
        mplier_d   = mplier_q >> 1;
        if (mplier_d == '0) begin
          state_d  = StFinish;
          result_d = acc_q;
          zero_d   = (acc_q == '0);
        end else begin
          state_d = mplier_d[0] ? StMulAdd : StMulShift;
        end
      end

      StFinish: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= StIdle;
      op_q     <= '0;
      work_q   <= '0;
      op2_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      work_q   <= work_d;
      op2_q    <= op2_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign BUSY   = (state_q != StIdle);
  assign DONE   = (state_q == StFinish);
  assign RESULT = result_q;
  assign ZERO   = zero_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Randomized and directed bench for alu_seq_ctrl with a behavioural ALU and a
// whole-operation reference model (result and DONE latency).
module tb_alu_seq_ctrl;

  logic       CLK;
  logic       RESET;
  logic       START;
  logic [2:0] OPCODE;
  logic [7:0] OPERAND1;
  logic [7:0] OPERAND2;
  logic [2:0] ALU_SELECT;
  logic [7:0] ALU_DATA1;
  logic [7:0] ALU_DATA2;
  logic [7:0] ALU_RESULT;
  logic       BUSY;
  logic       DONE;
  logic [7:0] RESULT;
  logic       ZERO;

  int n_checks = 0;
  int n_pass   = 0;
  logic [2:0] sels[$];

  alu_seq_ctrl #(.WIDTH(8)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .START      (START),
    .OPCODE     (OPCODE),
    .OPERAND1   (OPERAND1),
    .OPERAND2   (OPERAND2),
    .ALU_SELECT (ALU_SELECT),
    .ALU_DATA1  (ALU_DATA1),
    .ALU_DATA2  (ALU_DATA2),
    .ALU_RESULT (ALU_RESULT),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .RESULT     (RESULT),
    .ZERO       (ZERO)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Behavioural ALU the sequencer drives.
  always_comb begin
    logic [15:0] dd;
    dd = {ALU_DATA1, ALU_DATA1} >> ALU_DATA2[2:0];
    case (ALU_SELECT)
      3'b000:  ALU_RESULT = ALU_DATA1;
      3'b001:  ALU_RESULT = ALU_DATA1 + ALU_DATA2;
      3'b010:  ALU_RESULT = ALU_DATA1 & ALU_DATA2;
      3'b011:  ALU_RESULT = ALU_DATA1 | ALU_DATA2;
      3'b101:  ALU_RESULT = ALU_DATA1 << ALU_DATA2;
      3'b110:  ALU_RESULT = $signed(ALU_DATA1) >>> ALU_DATA2;
      3'b111:  ALU_RESULT = dd[7:0];
      default: ALU_RESULT = 8'h00;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Whole-operation model: final value and cycle of DONE counted from the accepting edge.
  function automatic void model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] r, output int lat);
    logic [15:0] t;
    int n, sa, hb;
    n  = (b > 8) ? 8 : int'(b);
    lat = 2;
    case (op)
      3'd0: r = a;
      3'd1: r = a + b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: begin
        t = 16'(a) * 16'(b);
        r = t[7:0];
        hb = -1;
        for (int i = 0; i < 8; i++) if (b[i]) hb = i;
        lat = (b == 0) ? 1 : 1 + $countones(b) + hb + 1;
      end
      3'd5: begin
        t = {8'h00, a} << n;
        r = t[7:0];
        lat = 1 + ((n > 0) ? n : 1);
      end
      3'd6: begin
        sa = int'($signed(a));
        sa = sa >>> n;
        r = sa[7:0];
        lat = 1 + ((n > 0) ? n : 1);
      end
      default: begin
        n = int'(b) % 8;
        t = {a, a} >> n;
        r = t[7:0];
        lat = 1 + ((n > 0) ? n : 1);
      end
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b);
    logic [7:0] exp_r;
    int exp_lat, lat;
    model(op, a, b, exp_r, exp_lat);
    @(negedge CLK);
    START = 1'b1; OPCODE = op; OPERAND1 = a; OPERAND2 = b;
    @(posedge CLK); #1;
    START = 1'b0;
    lat = 0;
    sels.delete();
    for (int k = 1; k <= 40; k++) begin
      sels.push_back(ALU_SELECT);
      check({tag, ".busy"}, 32'(BUSY), 32'd1);
      if (DONE) begin
        lat = k;
        break;
      end
      @(posedge CLK); #1;
    end
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".result"}, 32'(RESULT), 32'(exp_r));
    check({tag, ".zero"}, 32'(ZERO), 32'(exp_r == 8'h00));
    @(posedge CLK); #1;
    check({tag, ".idle"}, {30'd0, BUSY, DONE}, 32'd0);
  endtask

  initial begin
    logic [2:0] op;
    logic [7:0] a, b;
    int dones;
    RESET = 1'b1; START = 1'b0; OPCODE = 3'd0; OPERAND1 = 8'h00; OPERAND2 = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    check("rst.busy_done", {30'd0, BUSY, DONE}, 32'd0);
    check("rst.result", 32'(RESULT), 32'd0);
    check("rst.zero", 32'(ZERO), 32'd1);
    check("rst.sel", 32'(ALU_SELECT), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;

    run_op("add", 3'd1, 8'd20, 8'd22);
    check("add.sel", 32'(sels[0]), 32'd1);
    run_op("and", 3'd2, 8'h0F, 8'hF0);
    run_op("fwd", 3'd0, 8'h5A, 8'h33);
    run_op("or", 3'd3, 8'h50, 8'h0A);
    run_op("mul3x5", 3'd4, 8'd3, 8'd5);
    check("mul3x5.sels", {sels[0], sels[1], sels[2], sels[3], sels[4], sels[5]},
          32'({3'b001, 3'b101, 3'b101, 3'b001, 3'b101, 3'b000}));
    run_op("mulneg", 3'd4, 8'hFD, 8'd5);
    run_op("mul0", 3'd4, 8'd7, 8'd0);
    run_op("sra3", 3'd6, 8'h90, 8'd3);
    run_op("sra200", 3'd6, 8'h90, 8'd200);
    run_op("sl0", 3'd5, 8'h81, 8'd0);
    check("sl0.sel", 32'(sels[0]), 32'd0);
    run_op("ror9", 3'd7, 8'h01, 8'd9);
    run_op("ror8", 3'd7, 8'hA5, 8'd8);

    // START during EXEC and during FINISH must be ignored.
    @(negedge CLK);
    START = 1'b1; OPCODE = 3'd6; OPERAND1 = 8'h90; OPERAND2 = 8'd8;
    @(posedge CLK); #1;
    START = 1'b0;
    dones = 0;
    for (int k = 1; k <= 15; k++) begin
      if (DONE) begin
        dones++;
        check("ign.result", 32'(RESULT), 32'hFF);
      end
      START = (k == 3 || k == 9);
      OPCODE = 3'd1; OPERAND1 = 8'd1; OPERAND2 = 8'd1;
      @(posedge CLK); #1;
      START = 1'b0;
    end
    check("ign.dones", dones, 32'd1);
    check("ign.busy", 32'(BUSY), 32'd0);
    run_op("after_ign", 3'd1, 8'd100, 8'd55);

    // Reset in the third cycle of MULT 3x5.
    @(negedge CLK);
    START = 1'b1; OPCODE = 3'd4; OPERAND1 = 8'd3; OPERAND2 = 8'd5;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    check("mrst.busy_done", {30'd0, BUSY, DONE}, 32'd0);
    check("mrst.result", 32'(RESULT), 32'd0);
    check("mrst.zero", 32'(ZERO), 32'd1);
    check("mrst.sel", 32'(ALU_SELECT), 32'd0);
    RESET = 1'b0;
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge CLK); #1;
      if (DONE || BUSY) dones++;
    end
    check("mrst.quiet", dones, 32'd0);

    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom);
      b  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 10)) : 8'($urandom);
      run_op("rand", op, a, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
